csa_result_checker: RTL and testbench
=====================================

Name: csa_result_checker

Overview:
- Synthesizable, clocked response checker that sits on the output side of a WIDTH-bit carry-select adder (CSA) under test.
- A stimulus source drives a, b and cin into the adder. This block samples the same operands together with the adder's sum and cout, recomputes the golden result, and scores every vector.
- It counts passes and mismatches, captures the first failing vector, and declares pass/fail after NUM_VECTORS checks. This gives on-chip or in-bench self-checking for the ALU adders.

Parameters:
- WIDTH, 2, operand and sum width in bits.
- COUNT_W, 16, width of the checked and mismatch counters.
- NUM_VECTORS, 16, number of vectors scored before the run completes; legal range 1 .. 2^COUNT_W-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run.
- valid  input  1  the a, b, cin, sum and cout inputs form one vector this cycle.
- a  input  WIDTH  operand A as applied to the DUT.
- b  input  WIDTH  operand B as applied to the DUT.
- cin  input  1  carry-in as applied to the DUT.
- sum  input  WIDTH  DUT sum.
- cout  input  1  DUT carry-out.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  done and zero mismatches.
- err_pulse  output  1  one-cycle pulse per mismatch.
- checked_cnt  output  COUNT_W  vectors scored this run.
- mismatch_cnt  output  COUNT_W  mismatching vectors this run.
- fail_a  output  WIDTH  a of the first mismatch.
- fail_b  output  WIDTH  b of the first mismatch.
- fail_cin  output  1  cin of the first mismatch.
- fail_valid  output  1  the fail_* outputs hold a captured vector.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset is high, state is IDLE.
  - All outputs are 0, including every counter, every fail_* output and the internal pipeline registers.
  - Reset asserted mid-run aborts the run immediately. No partial result is retained.
- States:
  - IDLE:
    - start=1 goes to RUN on the next edge.
    - The same edge clears checked_cnt, mismatch_cnt, fail_valid and fail_*.
    - valid is ignored.
  - RUN:
    - Each cycle with valid=1 registers a, b, cin, sum and cout into stage 1.
    - Stage 1 computes expected = a + b + cin at WIDTH+1 bits. Bits [WIDTH-1:0] are compared with sum; bit WIDTH is compared with cout.
    - On the edge after capture, checked_cnt increments. On a mismatch, mismatch_cnt also increments and err_pulse is high for that one cycle.
    - Latency from a valid vector to its count update and err_pulse is exactly 1 cycle. Back-to-back valid is accepted every cycle.
    - start is ignored in RUN.
  - DONE entry:
    - RUN moves to DONE on the edge where checked_cnt becomes NUM_VECTORS.
    - A valid input arriving in that same cycle is dropped and not scored.
  - DONE:
    - done=1, and pass = (mismatch_cnt == 0).
    - Counters and fail_* outputs hold.
    - start=1 goes to RUN with the same clearing as the IDLE exit, so outputs stay stable until the next start.
- First-fail capture:
  - On the first mismatch of a run, fail_a, fail_b and fail_cin load the stage-1 operands and fail_valid becomes 1.
  - Later mismatches do not overwrite them.
- Arithmetic:
  - The golden sum is computed at full WIDTH+1 width with no truncation.
  - The all-ones case must wrap correctly: with WIDTH=2, a=3, b=3, cin=1 gives sum=3 and cout=1.
- Counters saturate at 2^COUNT_W-1 and never wrap.
- busy, done and pass are registered state decodes. err_pulse is registered.

Optional Feature:
- Macro name: CSA_CHECKER_SECOND_OUT_EN.
- Defined:
  - Adds input second_out (1 bit), the DUT's carry out of bit 0 (the low-half carry inside the carry-select structure).
  - The expected value is the carry of a[0] + b[0] + cin.
  - A vector mismatches if sum, cout or second_out differs.
  - second_out is pipelined with the other stage-1 inputs.
- Undefined: the port does not exist, and only sum and cout are checked.

Test Plan:
- Reset mid-run: start, then apply 5 valid vectors, then pulse reset -> all outputs return to 0 and the state is IDLE. After that, start plus 16 correct vectors -> checked_cnt=16, done=1, pass=1.
- Exhaustive correct run (WIDTH=2, NUM_VECTORS=32): all 32 (a, b, cin) combinations with a correct model -> mismatch_cnt=0, pass=1, err_pulse never high.
- Injected error: vector a=2, b=1, cin=1 with sum=3, cout=0 (expected sum=0, cout=1) -> err_pulse high exactly 1 cycle later, mismatch_cnt=1, fail_a=2, fail_b=1, fail_cin=1, and pass=0 at done.
- First-fail hold: two bad vectors, (1,1,0) then (3,2,1) -> fail_* still hold a=1, b=1, cin=0, and mismatch_cnt=2.
- Wrap and overrun: a=3, b=3, cin=1 with sum=3, cout=1 -> no error. A valid input on the completing cycle and valid inputs in DONE -> checked_cnt stays at NUM_VECTORS. start in DONE -> counters clear to 0.
- With CSA_CHECKER_SECOND_OUT_EN defined: a=1, b=0, cin=1 with second_out=0 (expected 1) and sum and cout otherwise correct -> err_pulse fires and mismatch_cnt=1.

Source files
------------

// File: rtl/csa_result_checker.sv
// Scoreboard for a WIDTH-bit carry-select adder: recomputes a+b+cin, counts passes/mismatches, holds the first failure.
// Optional macro CSA_CHECKER_SECOND_OUT_EN adds checking of the DUT's low-half carry (second_out).
module csa_result_checker #(
  parameter int WIDTH       = 2,
  parameter int COUNT_W     = 16,
  parameter int NUM_VECTORS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
`ifdef CSA_CHECKER_SECOND_OUT_EN
  input  logic               second_out,
`endif
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] checked_cnt,
  output logic [COUNT_W-1:0] mismatch_cnt,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_cin,
  output logic               fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(NUM_VECTORS - 1);

  state_t             state_q, state_d;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_sum_q, s1_sum_d;
  logic               s1_cin_q, s1_cin_d, s1_cout_q, s1_cout_d;
  logic               s1_second_q, s1_second_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] checked_q, checked_d, mismatch_q, mismatch_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic               fail_cin_q, fail_cin_d, fail_valid_q, fail_valid_d;

  logic [WIDTH:0]     expected;
  logic               exp_low_carry;
  logic               mismatch;
  logic               completing;
  logic               second_in;

`ifdef CSA_CHECKER_SECOND_OUT_EN
  assign second_in = second_out;
`else
  assign second_in = 1'b0;
`endif

  always_comb begin
    expected      = ({1'b0, s1_a_q} + {1'b0, s1_b_q}) + (WIDTH+1)'(s1_cin_q);
    exp_low_carry = (s1_a_q[0] & s1_b_q[0]) | (s1_cin_q & (s1_a_q[0] ^ s1_b_q[0]));
    mismatch      = (expected[WIDTH-1:0] != s1_sum_q) || (expected[WIDTH] != s1_cout_q);
`ifdef CSA_CHECKER_SECOND_OUT_EN
    mismatch      = mismatch || (exp_low_carry != s1_second_q);
`endif
    mismatch      = mismatch && s1_valid_q;
    // The vector scored on this edge may be the last one; a new valid arriving alongside it is dropped.
    completing    = s1_valid_q && (checked_q == CNT_LAST);
  end

  always_comb begin
    state_d      = state_q;
    s1_valid_d   = 1'b0;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_cin_d     = s1_cin_q;
    s1_sum_d     = s1_sum_q;
    s1_cout_d    = s1_cout_q;
    s1_second_d  = s1_second_q;
    err_d        = 1'b0;
    checked_d    = checked_q;
    mismatch_d   = mismatch_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_cin_d   = fail_cin_q;
    fail_valid_d = fail_valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          checked_d    = '0;
          mismatch_d   = '0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_cin_d   = 1'b0;
          fail_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (s1_valid_q) begin
          if (checked_q != CNT_MAX) checked_d = checked_q + COUNT_W'(1);
          if (mismatch) begin
            err_d = 1'b1;
            if (mismatch_q != CNT_MAX) mismatch_d = mismatch_q + COUNT_W'(1);
            if (!fail_valid_q) begin
              fail_a_d     = s1_a_q;
              fail_b_d     = s1_b_q;
              fail_cin_d   = s1_cin_q;
              fail_valid_d = 1'b1;
            end
          end
        end
        if (completing) begin
          state_d = DONE;
        end else if (valid) begin
          s1_valid_d  = 1'b1;
          s1_a_d      = a;
          s1_b_d      = b;
          s1_cin_d    = cin;
          s1_sum_d    = sum;
          s1_cout_d   = cout;
          s1_second_d = second_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_cin_q     <= 1'b0;
      s1_sum_q     <= '0;
      s1_cout_q    <= 1'b0;
      s1_second_q  <= 1'b0;
      err_q        <= 1'b0;
      checked_q    <= '0;
      mismatch_q   <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_cin_q   <= 1'b0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_cin_q     <= s1_cin_d;
      s1_sum_q     <= s1_sum_d;
      s1_cout_q    <= s1_cout_d;
      s1_second_q  <= s1_second_d;
      err_q        <= err_d;
      checked_q    <= checked_d;
      mismatch_q   <= mismatch_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_cin_q   <= fail_cin_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign pass         = (state_q == DONE) && (mismatch_q == '0);
  assign err_pulse    = err_q;
  assign checked_cnt  = checked_q;
  assign mismatch_cnt = mismatch_q;
  assign fail_a       = fail_a_q;
  assign fail_b       = fail_b_q;
  assign fail_cin     = fail_cin_q;
  assign fail_valid   = fail_valid_q;

endmodule

// File: tb/tb_csa_result_checker.sv
// Directed self-checking bench for csa_result_checker (WIDTH=2, COUNT_W=16, NUM_VECTORS=16).
module tb_csa_result_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        valid;
  logic [1:0]  a, b, sum;
  logic        cin, cout;
  logic        second_out;
  logic        busy, done, pass, err_pulse;
  logic [15:0] checked_cnt, mismatch_cnt;
  logic [1:0]  fail_a, fail_b;
  logic        fail_cin, fail_valid;

  int checks;
  int errors;
  int err_seen;

  csa_result_checker #(.WIDTH(2), .COUNT_W(16), .NUM_VECTORS(16)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .valid(valid),
    .a(a),
    .b(b),
    .cin(cin),
    .sum(sum),
    .cout(cout),
`ifdef CSA_CHECKER_SECOND_OUT_EN
    .second_out(second_out),
`endif
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_pulse(err_pulse),
    .checked_cnt(checked_cnt),
    .mismatch_cnt(mismatch_cnt),
    .fail_a(fail_a),
    .fail_b(fail_b),
    .fail_cin(fail_cin),
    .fail_valid(fail_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and sample #1 after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (err_pulse === 1'b1) err_seen++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] va, input logic [1:0] vb,
                               input logic vcin, input logic [1:0] vsum, input logic vcout,
                               input logic vsecond);
    valid      = v;
    a          = va;
    b          = vb;
    cin        = vcin;
    sum        = vsum;
    cout       = vcout;
    second_out = vsecond;
    tick();
    valid      = 1'b0;
  endtask

  // Correct adder response for vector index {a, b, cin}.
  task automatic applyGood(input int idx);
    logic [1:0] ga, gb;
    logic       gc;
    logic [2:0] total;
    logic       low_carry;
    ga        = idx[4:3];
    gb        = idx[2:1];
    gc        = idx[0];
    total     = {1'b0, ga} + {1'b0, gb} + {2'b00, gc};
    low_carry = (ga[0] + gb[0] + gc) > 1;
    applyStimulus(1'b1, ga, gb, gc, total[1:0], total[2], low_carry);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_pass"}, {31'd0, pass}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err_pulse}, 32'd0);
    checkOutput({tag, "_checked"}, {16'd0, checked_cnt}, 32'd0);
    checkOutput({tag, "_mismatch"}, {16'd0, mismatch_cnt}, 32'd0);
    checkOutput({tag, "_fail_a"}, {30'd0, fail_a}, 32'd0);
    checkOutput({tag, "_fail_b"}, {30'd0, fail_b}, 32'd0);
    checkOutput({tag, "_fail_cin"}, {31'd0, fail_cin}, 32'd0);
    checkOutput({tag, "_fail_valid"}, {31'd0, fail_valid}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    err_seen   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    valid      = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    sum        = '0;
    cout       = 1'b0;
    second_out = 1'b0;

    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    // Abort a run partway through with reset.
    pulseStart();
    checkOutput("run1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) applyGood(i);
    idleCycle();
    checkOutput("run1_checked5", {16'd0, checked_cnt}, 32'd5);
    reset = 1'b1;
    #2;
    checkAllZero("midreset");
    tick();
    reset = 1'b0;
    tick();

    // First half of the exhaustive space, all correct.
    err_seen = 0;
    pulseStart();
    for (int i = 0; i < 16; i++) applyGood(i);
    checkOutput("run2_not_done_yet", {31'd0, done}, 32'd0);
    idleCycle();
    checkOutput("run2_checked", {16'd0, checked_cnt}, 32'd16);
    checkOutput("run2_done", {31'd0, done}, 32'd1);
    checkOutput("run2_pass", {31'd0, pass}, 32'd1);
    checkOutput("run2_busy", {31'd0, busy}, 32'd0);
    checkOutput("run2_err_seen", err_seen, 32'd0);

    // Restart from DONE clears counters; second half includes the all-ones wrap case.
    err_seen = 0;
    pulseStart();
    checkOutput("run3_cleared", {16'd0, checked_cnt}, 32'd0);
    checkOutput("run3_busy", {31'd0, busy}, 32'd1);
    checkOutput("run3_done_low", {31'd0, done}, 32'd0);
    for (int i = 16; i < 32; i++) applyGood(i);
    idleCycle();
    checkOutput("run3_checked", {16'd0, checked_cnt}, 32'd16);
    checkOutput("run3_mismatch", {16'd0, mismatch_cnt}, 32'd0);
    checkOutput("run3_pass", {31'd0, pass}, 32'd1);
    checkOutput("run3_err_seen", err_seen, 32'd0);

    // Injected error plus overrun on the completing cycle and in DONE.
    err_seen = 0;
    pulseStart();
    applyStimulus(1'b1, 2'd2, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("run4_err_not_yet", {31'd0, err_pulse}, 32'd0);
    applyGood(0);
    checkOutput("run4_err_latency", {31'd0, err_pulse}, 32'd1);
    checkOutput("run4_mismatch1", {16'd0, mismatch_cnt}, 32'd1);
    checkOutput("run4_checked1", {16'd0, checked_cnt}, 32'd1);
    applyGood(1);
    checkOutput("run4_err_one_cycle", {31'd0, err_pulse}, 32'd0);
    for (int i = 2; i < 15; i++) applyGood(i);
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("run4_done_at_16", {31'd0, done}, 32'd1);
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("run4_checked_hold", {16'd0, checked_cnt}, 32'd16);
    checkOutput("run4_mismatch_hold", {16'd0, mismatch_cnt}, 32'd1);
    checkOutput("run4_pass", {31'd0, pass}, 32'd0);
    checkOutput("run4_fail_a", {30'd0, fail_a}, 32'd2);
    checkOutput("run4_fail_b", {30'd0, fail_b}, 32'd1);
    checkOutput("run4_fail_cin", {31'd0, fail_cin}, 32'd1);
    checkOutput("run4_fail_valid", {31'd0, fail_valid}, 32'd1);
    checkOutput("run4_err_seen", err_seen, 32'd1);

    // Two bad vectors: only the first is captured.
    pulseStart();
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) applyGood(i);
    idleCycle();
    checkOutput("run5_done", {31'd0, done}, 32'd1);
    checkOutput("run5_mismatch", {16'd0, mismatch_cnt}, 32'd2);
    checkOutput("run5_fail_a", {30'd0, fail_a}, 32'd1);
    checkOutput("run5_fail_b", {30'd0, fail_b}, 32'd1);
    checkOutput("run5_fail_cin", {31'd0, fail_cin}, 32'd0);
    checkOutput("run5_pass", {31'd0, pass}, 32'd0);

`ifdef CSA_CHECKER_SECOND_OUT_EN
    // Correct sum/cout but wrong low-half carry.
    pulseStart();
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    idleCycle();
    checkOutput("second_err", {31'd0, err_pulse}, 32'd1);
    checkOutput("second_mismatch", {16'd0, mismatch_cnt}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
